// File: rtl/bcd2bin.sv
// Sequential 4-digit BCD to binary converter using reverse double-dabble.
// Uses the same start/ready/done_tick handshake as the binary-to-BCD converter.
module bcd2bin #(
  parameter int N_ITER = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        bcd3,
  input  logic [3:0]        bcd2,
  input  logic [3:0]        bcd1,
  input  logic [3:0]        bcd0,
  output logic              ready,
  output logic              done_tick,
  output logic [N_ITER-1:0] bin,
  output logic              err
);

  localparam int CW = $clog2(N_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [N_ITER-1:0] sreg_q, sreg_d;
  logic              err_flag_q, err_flag_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [N_ITER-1:0] bin_q, bin_d;
  logic              err_q, err_d;

  logic [N_ITER+15:0] word_sh;
  logic [15:0]        bcd_fix;
  logic               digit_bad;

  // One right shift of the joint {bcd, bin} word, then each BCD digit that
  // received a carried-in half-weight bit (value >= 8) is corrected by -3.
  always_comb begin
    word_sh = {bcd_q, sreg_q} >> 1;
    bcd_fix = word_sh[N_ITER +: 16];
    for (int i = 0; i < 4; i++) begin
      if (word_sh[N_ITER + 4*i +: 4] >= 4'd8) begin
        bcd_fix[4*i +: 4] = word_sh[N_ITER + 4*i +: 4] - 4'd3;
      end
    end
  end

  assign digit_bad = (bcd3 > 4'd9) | (bcd2 > 4'd9) | (bcd1 > 4'd9) | (bcd0 > 4'd9);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    sreg_d     = sreg_q;
    err_flag_d = err_flag_q;
    bin_d      = bin_q;
    err_d      = err_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d  = {bcd3, bcd2, bcd1, bcd0};
          sreg_d = '0;
          if (digit_bad) begin
            err_flag_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            err_flag_d = 1'b0;
            cnt_d      = CW'(N_ITER - 1);
            state_d    = S_OP;
          end
        end
      end
      S_OP: begin
        bcd_d  = bcd_fix;
        sreg_d = word_sh[N_ITER-1:0];
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        bin_d   = err_flag_q ? '0 : sreg_q;
        err_d   = err_flag_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bcd_q      <= '0;
      sreg_q     <= '0;
      err_flag_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      bin_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      sreg_q     <= sreg_d;
      err_flag_q <= err_flag_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      bin_q      <= bin_d;
      err_q      <= err_d;
    end
  end

  assign ready     = ready_q;
  assign done_tick = done_q;
  assign bin       = bin_q;
  assign err       = err_q;

endmodule
